// File: rtl/block_serializer_pkg.sv
// Shared types and constants for the block serializer and its block buffer.
// Block width, byte width and the serializer state encoding live here.
package block_serializer_pkg;

    localparam int BLOCK_W         = 128;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 16;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/block_serializer_fifo.sv
// Circular buffer of 128-bit blocks; a push into a full buffer is accepted
// only when a pop frees a slot in the same cycle.
module block_fifo
    import block_serializer_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         push,
    input  logic                         pop,
    input  block_t                       wr_data,
    output block_t                       rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(BUF_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    block_t           mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PTR_W+1)'(BUF_DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because BUF_DEPTH is a power of two
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push && !rst_in) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/block_serializer.sv
// Buffers deciphered 128-bit blocks and emits them MSB byte first over a
// valid/ready byte stream, with a one-cycle reload gap between blocks.
module block_serializer
    import block_serializer_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  block_t      block_in,
    input  logic        block_valid_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid_out,
    input  logic        byte_ready_in,
    output logic        last_byte_out,
    output logic        busy_out,
    output logic        overflow_out
);

    localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_BLOCK - 1);

    ser_state_t                  state;
    block_t                      shift;
    logic [3:0]                  byte_cnt;
    logic                        overflow;
    block_t                      head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(BUF_DEPTH):0]  fifo_count;
    logic                        pop;
    logic                        push;
    logic                        drop;

    assign push = block_valid_in && !rst_in;
    assign pop  = (state == IDLE) && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    block_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (push),
        .pop     (pop),
        .wr_data (block_in),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // IDLE spends exactly one cycle reloading, which yields the inter-block gap
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            shift    <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= head;
                        byte_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (byte_ready_in) begin
                        shift    <= {shift[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == LAST_IDX) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_out       = shift[BLOCK_W-1 -: BYTE_W];
    assign byte_valid_out = (state == SEND);
    assign last_byte_out  = (state == SEND) && (byte_cnt == LAST_IDX);
    assign busy_out       = (state == SEND) || (fifo_count != '0);
    assign overflow_out   = overflow;

endmodule

// File: tb/tb_block_serializer.sv
// Directed bench for block_serializer: byte expectations are queued when a
// block is driven and compared as the serializer transfers each byte.
module tb_block_serializer;
    import block_serializer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    block_t      block_in;
    logic        block_valid_in;
    logic [7:0]  byte_out;
    logic        byte_valid_out;
    logic        byte_ready_in;
    logic        last_byte_out;
    logic        busy_out;
    logic        overflow_out;

    block_serializer #(.BUF_DEPTH(2)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .block_in       (block_in),
        .block_valid_in (block_valid_in),
        .byte_out       (byte_out),
        .byte_valid_out (byte_valid_out),
        .byte_ready_in  (byte_ready_in),
        .last_byte_out  (last_byte_out),
        .busy_out       (busy_out),
        .overflow_out   (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         xfer_cnt    = 0;
    logic       prev_valid  = 1'b0;
    logic       prev_ready  = 1'b0;
    logic [7:0] prev_byte   = 8'h00;

    localparam block_t BLK_X = 128'h00112233445566778899AABBCCDDEEFF;
    localparam block_t BLK_A = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    localparam block_t BLK_B = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    localparam block_t BLK_C = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    localparam block_t BLK_D = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;
    localparam block_t BLK_E = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;
    localparam block_t BLK_F = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    localparam block_t BLK_G = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam block_t BLK_H = 128'h5A5A1234C3C3ABCD0F0FF0F087654321;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_bytes(input block_t blk, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b    = blk[127 - 8*i -: 8];
            e.last = (i == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (rst_in) begin
            prev_valid = 1'b0;
            return;
        end
        if (prev_valid && !prev_ready) begin
            check("stall_valid", byte_valid_out, 1'b1);
            check("stall_byte", byte_out, prev_byte);
        end
        if (byte_valid_out && byte_ready_in) begin
            xfer_cnt++;
            check("byte_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("byte_out", byte_out, e.b);
                check("last_byte", last_byte_out, e.last);
            end
        end
        prev_valid = byte_valid_out;
        prev_ready = byte_ready_in;
        prev_byte  = byte_out;
    endtask

    // Compare at the falling edge, then advance to just after the next rising edge
    task automatic tick();
        @(negedge clk_in);
        sample();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 400; c++) begin
            if (exp_q.size() == 0 && !busy_out) break;
            tick();
        end
        check({tag, "_drained"}, (exp_q.size() == 0) && !busy_out, 1'b1);
    endtask

    task automatic pulse(input block_t blk);
        block_in       = blk;
        block_valid_in = 1'b1;
        tick();
        block_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        int base;
        rst_in         = 1'b1;
        block_in       = BLK_D;
        block_valid_in = 1'b1;
        byte_ready_in  = 1'b0;
        tick();
        tick();
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_valid", byte_valid_out, 1'b0);
        check("rst_last", last_byte_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_overflow", overflow_out, 1'b0);
        rst_in         = 1'b0;
        block_valid_in = 1'b0;
        tick();
        check("rst_ignored_pulse", busy_out, 1'b0);

        // Single block, ready held high: valid two cycles after the pulse, 16 cycles long
        byte_ready_in = 1'b1;
        push_bytes(BLK_X, 16);
        pulse(BLK_X);
        check("lat_n1_valid", byte_valid_out, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            check("send_cycle_valid", byte_valid_out, 1'b1);
            tick();
        end
        check("after_block_valid", byte_valid_out, 1'b0);
        check("after_block_busy", busy_out, 1'b0);
        drain("single");

        // Backpressure with ready pattern 1,0,0,1,0,0,...
        base = xfer_cnt;
        push_bytes(BLK_X, 16);
        pulse(BLK_X);
        for (int c = 0; c < 200; c++) begin
            byte_ready_in = (c % 3 == 0);
            tick();
            if (exp_q.size() == 0 && !busy_out) break;
        end
        check("bp_transfers", xfer_cnt - base, 16);
        drain("backpressure");

        // Overflow: A held in the shift register, B and C buffered, D dropped
        byte_ready_in = 1'b0;
        push_bytes(BLK_A, 16);
        push_bytes(BLK_B, 16);
        push_bytes(BLK_C, 16);
        block_valid_in = 1'b1;
        block_in = BLK_A; tick();
        block_in = BLK_B; tick();
        block_in = BLK_C; tick();
        check("ovf_before_d", overflow_out, 1'b0);
        block_in = BLK_D; tick();
        block_valid_in = 1'b0;
        check("ovf_after_d", overflow_out, 1'b1);
        check("ovf_head_byte", byte_out, 8'hA0);
        check("ovf_busy", busy_out, 1'b1);
        byte_ready_in = 1'b1;
        drain("overflow");
        check("ovf_sticky", overflow_out, 1'b1);
        do_reset();
        check("ovf_cleared_by_reset", overflow_out, 1'b0);

        // Full buffer plus pop: E arrives in the reload cycle that pops B
        byte_ready_in = 1'b0;
        push_bytes(BLK_A, 16);
        push_bytes(BLK_B, 16);
        push_bytes(BLK_C, 16);
        push_bytes(BLK_E, 16);
        block_valid_in = 1'b1;
        block_in = BLK_A; tick();
        block_in = BLK_B; tick();
        block_in = BLK_C; tick();
        block_valid_in = 1'b0;
        byte_ready_in = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (last_byte_out) break;
            tick();
        end
        check("fp_last_seen", last_byte_out, 1'b1);
        tick();
        check("fp_reload_gap", byte_valid_out, 1'b0);
        pulse(BLK_E);
        drain("full_pop");
        check("fp_no_overflow", overflow_out, 1'b0);

        // Reset after 5 bytes of F with G buffered; neither may reappear
        byte_ready_in = 1'b1;
        push_bytes(BLK_F, 5);
        pulse(BLK_F);
        pulse(BLK_G);
        for (int i = 0; i < 5; i++) tick();
        check("mid_sent_five", exp_q.size(), 0);
        rst_in         = 1'b1;
        block_in       = BLK_D;
        block_valid_in = 1'b1;
        tick();
        check("mid_rst_byte", byte_out, 8'h00);
        check("mid_rst_valid", byte_valid_out, 1'b0);
        check("mid_rst_last", last_byte_out, 1'b0);
        check("mid_rst_busy", busy_out, 1'b0);
        check("mid_rst_ovf", overflow_out, 1'b0);
        rst_in         = 1'b0;
        block_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_quiet", {byte_valid_out, busy_out}, 2'b00);
        end
        push_bytes(BLK_H, 16);
        pulse(BLK_H);
        drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
